// File: rtl/chunked_compare_unit_pkg.sv
// Shared definitions for the chunked compare unit.
//   compare_unit_op_t  : comparison opcode (EQ, NE, LT, GE, LTU, GEU); the
//                        encodings 6 and 7 are undefined and yield a 0 result.
//   chunk_cmp_state_t  : control FSM states of the chunked compare unit.
package definitions;

  typedef enum logic [2:0] {
    EQ  = 3'd0,
    NE  = 3'd1,
    LT  = 3'd2,
    GE  = 3'd3,
    LTU = 3'd4,
    GEU = 3'd5
  } compare_unit_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } chunk_cmp_state_t;

endpackage

// File: rtl/chunked_compare_unit_if.sv
// Request/result handshake bundle of the chunked compare unit.
//   valid_i / ready_o                    : request handshake (requester -> unit)
//   compare_unit_op_i, in1_i, in2_i      : request payload
//   valid_o / ready_i                    : result handshake (unit -> consumer)
//   res_o                                : one-bit comparison result
// The master modport is the requester/consumer side, slave is the unit.
interface chunked_compare_unit_if #(
  parameter int WIDTH = 32
);
  import definitions::*;

  logic             valid_i;
  logic             ready_o;
  compare_unit_op_t compare_unit_op_i;
  logic [WIDTH-1:0] in1_i;
  logic [WIDTH-1:0] in2_i;
  logic             valid_o;
  logic             ready_i;
  logic             res_o;

  modport master (
    output valid_i, compare_unit_op_i, in1_i, in2_i, ready_i,
    input  ready_o, valid_o, res_o
  );

  modport slave (
    input  valid_i, compare_unit_op_i, in1_i, in2_i, ready_i,
    output ready_o, valid_o, res_o
  );

endinterface

// File: rtl/chunked_compare_unit_chunk.sv
// compare_chunk: combinational compare of one CHUNK-bit slice pair.
//   a_i, b_i  : operand slices
//   signed_i  : 1 = two's-complement compare, 0 = unsigned compare
//   ne_o      : slices differ
//   lt_o      : a_i < b_i under the selected signedness
module compare_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             signed_i,
  output logic             ne_o,
  output logic             lt_o
);

  logic signed [CHUNK-1:0] a_s;
  logic signed [CHUNK-1:0] b_s;

  assign a_s  = a_i;
  assign b_s  = b_i;
  assign ne_o = (a_i != b_i);
  assign lt_o = signed_i ? (a_s < b_s) : (a_i < b_i);

endmodule

// File: rtl/chunked_compare_unit.sv
// chunked_compare_unit: multi-cycle comparator that walks two WIDTH-bit
// operands CHUNK bits per cycle, MSB chunk first, and returns one result bit
// per transaction over valid/ready handshakes.
//   clk_i     : clock, all state updates on the rising edge
//   reset_ni  : synchronous active-low reset
//   bus       : chunked_compare_unit_if.slave (request in, result out)
// Optional feature macro: COMPARE_EARLY_EXIT_EN -- when defined, SCAN ends on
// the first differing chunk; otherwise SCAN always visits all NCHUNK chunks.
// Results are identical in both builds, only latency differs.
module chunked_compare_unit
  import definitions::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  chunked_compare_unit_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  chunk_cmp_state_t state;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             lt;
  logic             res_q;
  compare_unit_op_t op_q;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;

  logic [CHUNK-1:0] c1;
  logic [CHUNK-1:0] c2;
  logic             chunk_ne;
  logic             chunk_lt;
  logic             use_signed;
  logic             last_chunk;
  logic             decided_nx;
  logic             lt_nx;
  logic             scan_exit;

  function automatic logic map_result(input compare_unit_op_t op,
                                      input logic dec, input logic l);
    logic r;
    case (op)
      EQ:       r = ~dec;
      NE:       r = dec;
      LT, LTU:  r = l;
      GE, GEU:  r = ~l;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  // Chunk select: idx 0 addresses the most significant chunk.
  always_comb begin
    c1 = '0;
    c2 = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) begin
        c1 = in1_q[(NCHUNK-1-i)*CHUNK +: CHUNK];
        c2 = in2_q[(NCHUNK-1-i)*CHUNK +: CHUNK];
      end
    end
  end

  // Only the sign-carrying MSB chunk is compared signed, and only for LT/GE.
  assign use_signed = ((op_q == LT) || (op_q == GE)) && (idx == '0);
  assign last_chunk = (idx == IDX_W'(NCHUNK - 1));

  compare_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i      (c1),
    .b_i      (c2),
    .signed_i (use_signed),
    .ne_o     (chunk_ne),
    .lt_o     (chunk_lt)
  );

  // Once decided, lt is frozen: later chunks cannot override the MSB-most
  // difference.
  assign decided_nx = decided | chunk_ne;
  assign lt_nx      = decided ? lt : (chunk_ne & chunk_lt);

`ifdef COMPARE_EARLY_EXIT_EN
  assign scan_exit = last_chunk | chunk_ne;
`else
  assign scan_exit = last_chunk;
`endif

  // Operand capture: data path, not reset.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && bus.valid_i) begin
      op_q  <= bus.compare_unit_op_i;
      in1_q <= bus.in1_i;
      in2_q <= bus.in2_i;
    end
  end

  // Control FSM.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state   <= IDLE;
      res_q   <= 1'b0;
      idx     <= '0;
      decided <= 1'b0;
      lt      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            idx     <= '0;
            decided <= 1'b0;
            lt      <= 1'b0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          decided <= decided_nx;
          lt      <= lt_nx;
          if (scan_exit) begin
            res_q <= map_result(op_q, decided_nx, lt_nx);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = (state == DONE);
  assign bus.res_o   = res_q;

endmodule

// File: tb/tb_chunked_compare_unit.sv
module tb_chunked_compare_unit;
  import definitions::*;

`ifdef COMPARE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tb_valid;
  compare_unit_op_t tb_op;
  logic [31:0]      tb_in1;
  logic [31:0]      tb_in2;
  logic             tb_ready;
  logic             sel = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunked_compare_unit_if #(.WIDTH(32)) ifa ();
  chunked_compare_unit_if #(.WIDTH(32)) ifb ();

  assign ifa.valid_i           = tb_valid;
  assign ifa.compare_unit_op_i = tb_op;
  assign ifa.in1_i             = tb_in1;
  assign ifa.in2_i             = tb_in2;
  assign ifa.ready_i           = tb_ready;
  assign ifb.valid_i           = tb_valid;
  assign ifb.compare_unit_op_i = tb_op;
  assign ifb.in1_i             = tb_in1;
  assign ifb.in2_i             = tb_in2;
  assign ifb.ready_i           = tb_ready;

  chunked_compare_unit #(.WIDTH(32), .CHUNK(8)) dut_a (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (ifa.slave)
  );

  chunked_compare_unit #(.WIDTH(32), .CHUNK(32)) dut_b (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (ifb.slave)
  );

  logic obs_valid, obs_ready, obs_res;
  assign obs_valid = sel ? ifb.valid_o : ifa.valid_o;
  assign obs_ready = sel ? ifb.ready_o : ifa.ready_o;
  assign obs_res   = sel ? ifb.res_o   : ifa.res_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, measure latency, check result, release.
  task automatic run_req(input bit s, input string tag, input compare_unit_op_t op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic exp_res, input int exp_lat);
    int cyc;
    sel = s;
    @(negedge clk);
    chk({tag, "_ready_in"}, 32'(obs_ready), 32'd1);
    tb_valid = 1'b1; tb_op = op; tb_in1 = a; tb_in2 = b;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    cyc = 0;
    while (!obs_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_res"}, 32'(obs_res), 32'(exp_res));
    tb_ready = 1'b1;
    @(posedge clk); #1;
    tb_ready = 1'b0;
    chk({tag, "_ready_out"}, 32'(obs_ready), 32'd1);
    chk({tag, "_valid_out"}, 32'(obs_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; tb_valid = 1'b0; tb_ready = 1'b0;
    tb_op = EQ; tb_in1 = '0; tb_in2 = '0;

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    chk("rst_a_ready", 32'(obs_ready), 32'd1);
    chk("rst_a_valid", 32'(obs_valid), 32'd0);
    chk("rst_a_res",   32'(obs_res),   32'd0);
    sel = 1'b1;
    #1;
    chk("rst_b_ready", 32'(obs_ready), 32'd1);
    chk("rst_b_valid", 32'(obs_valid), 32'd0);
    chk("rst_b_res",   32'(obs_res),   32'd0);
    rst_n = 1'b1;

    // WIDTH=32, CHUNK=8 directed vectors
    run_req(1'b0, "eq_equal",  EQ,  32'h12345678, 32'h12345678, 1'b1, 4);
    run_req(1'b0, "lt_signed", LT,  32'hFFFFFFFF, 32'h00000001, 1'b1, EE ? 1 : 4);
    run_req(1'b0, "ltu_same",  LTU, 32'hFFFFFFFF, 32'h00000001, 1'b0, EE ? 1 : 4);
    run_req(1'b0, "geu_chunk2",GEU, 32'h00000100, 32'h000000FF, 1'b1, EE ? 3 : 4);
    run_req(1'b0, "ne_last",   NE,  32'h00000010, 32'h00000011, 1'b1, 4);
    run_req(1'b0, "lt_lowuns", LT,  32'h00800000, 32'h00010000, 1'b0, EE ? 2 : 4);
    run_req(1'b0, "ge_lowuns", GE,  32'h00800000, 32'h00010000, 1'b1, EE ? 2 : 4);
    run_req(1'b0, "undef_a",   compare_unit_op_t'(3'd7), 32'h1, 32'h2, 1'b0, 4);

    // Backpressure in DONE with a competing request pulsed on valid_i
    sel = 1'b0;
    @(negedge clk);
    tb_valid = 1'b1; tb_op = LT; tb_in1 = 32'h5; tb_in2 = 32'h9;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    cyc = 0;
    while (!obs_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_lat", 32'(cyc), 32'd4);
    for (int i = 0; i < 5; i++) begin
      tb_valid = 1'b1; tb_op = EQ; tb_in1 = 32'hA; tb_in2 = 32'hB;
      @(posedge clk); #1;
      chk("bp_valid_hold", 32'(obs_valid), 32'd1);
      chk("bp_res_hold",   32'(obs_res),   32'd1);
      chk("bp_ready_low",  32'(obs_ready), 32'd0);
    end
    tb_valid = 1'b0;
    tb_ready = 1'b1;
    @(posedge clk); #1;
    tb_ready = 1'b0;
    chk("bp_release_ready", 32'(obs_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_not_captured", 32'(obs_valid), 32'd0);
    chk("bp_idle", 32'(obs_ready), 32'd1);

    // Reset asserted mid-SCAN at idx=1
    @(negedge clk);
    tb_valid = 1'b1; tb_op = EQ; tb_in1 = 32'hAAAAAAAA; tb_in2 = 32'hAAAAAAAA;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_scan_ready", 32'(obs_ready), 32'd1);
    chk("rst_scan_valid", 32'(obs_valid), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_scan_no_result", 32'(obs_valid), 32'd0);

    // WIDTH=32, CHUNK=32: single chunk is both signed and last
    run_req(1'b1, "b_ge_sign", GE, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1);
    run_req(1'b1, "b_lt_sign", LT, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1);
    run_req(1'b1, "b_undef", compare_unit_op_t'(3'd6), 32'h0, 32'h0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunked_compare_unit.md
# chunked_compare_unit

- Parametrised, multi-cycle successor to the single-cycle branch comparator.
- Compares two `WIDTH`-bit operands `CHUNK` bits per cycle, MSB chunk first, so wide operands fit a narrow datapath.
- Uses valid/ready handshakes on both sides and returns one result bit per transaction.
- Sits between the issue stage and branch resolution. Also used by the wide-operand (64-bit) compare paths.

## Interface
- `WIDTH`, default 32: operand width. Must be a multiple of `CHUNK`.
- `CHUNK`, default 8: bits compared per cycle. `NCHUNK = WIDTH/CHUNK`.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `reset_ni`  in  1  synchronous, active-low reset.
- `valid_i`  in  1  request valid.
- `ready_o`  out  1  unit can accept a request.
- `compare_unit_op_i`  in  `compare_unit_op_t`  EQ, NE, LT, GE, LTU, GEU.
- `in1_i`, `in2_i`  in  `WIDTH`  operands.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  consumer accepts result.
- `res_o`  out  1  comparison result.

## Operation
- FSM states:
  - IDLE: `ready_o`=1. On `valid_i`, capture op, `in1_i`, `in2_i`; clear `idx`, `decided` and `lt`; go to SCAN.
  - SCAN: examine chunk `idx` (MSB chunk is `idx`=0).
    - If not yet `decided` and the chunks differ: set `decided`=1 and set `lt` from the chunk compare.
    - Chunk compare is signed for LT/GE when `idx`=0, unsigned otherwise.
    - Leave SCAN for DONE when `idx`=`NCHUNK`-1, or (with early exit) when the current chunk differs.
    - Otherwise `idx`++.
  - DONE: `valid_o`=1. `res_o` is registered and stable. When `ready_i`=1, go to IDLE.
- Result mapping:
  - EQ → `!decided`; NE → `decided`.
  - LT, LTU → `lt`; GE, GEU → `!lt`.
  - Undefined op encoding → `res_o`=0.
- `ready_o` is combinational from state: high only in IDLE. `valid_i` outside IDLE is ignored.
- A result is never dropped or modified while `valid_o`=1 and `ready_i`=0.

## Timing
- Reset values: state IDLE, `valid_o`=0, `res_o`=0, `ready_o`=1 in the cycle after the reset edge.
- Latency:
  - Request accepted at edge k → `valid_o` rises after edge k+N.
  - N = position of the first differing chunk + 1 (1..`NCHUNK`). Equal operands give N=`NCHUNK`.
  - With early exit disabled, N=`NCHUNK` always.
- Result accepted at edge m → `ready_o`=1 in cycle m+1. No same-cycle accept of a new request while in DONE.
- Minimum period between requests is N+2 cycles.
- `reset_ni` low in any state, including mid-SCAN or DONE under backpressure: the next cycle is IDLE with `valid_o`=0. The in-flight transaction is discarded with no result.
- `idx` width is `$clog2(NCHUNK)`, minimum 1 bit. `NCHUNK`=1 makes the single chunk both the signed chunk and the last chunk.
- Signed compare applies only to the MSB chunk. Lower chunks always compare unsigned.

## Configuration
- `COMPARE_EARLY_EXIT_EN` defined:
  - SCAN terminates on the first differing chunk.
  - Latency is data-dependent.
- Not defined:
  - SCAN always runs `NCHUNK` cycles.
  - `decided` freezes `lt`, so remaining chunks are examined but ignored.
  - Latency is a fixed `NCHUNK`+… as above, i.e. N=`NCHUNK`.
- Results are identical in both builds.

## Structure
- Shared package `definitions`:
  - `compare_unit_op_t`, unchanged encoding.
  - FSM state enum `chunk_cmp_state_t` (IDLE, SCAN, DONE).
- One sub-module, `compare_chunk`:
  - Combinational; `CHUNK`-bit operands plus a `signed_i` select.
  - Outputs `ne_o` and `lt_o`.
  - Instantiated once, fed by the `idx`-selected slices.

## Test plan
- WIDTH=32, CHUNK=8, EQ, 0x12345678 vs 0x12345678 → `res_o`=1, `valid_o` 4 cycles after accept.
- LT, 0xFFFFFFFF vs 0x00000001 → `res_o`=1; LTU same operands → `res_o`=0.
  - Both decide at chunk 0: latency 1 with `COMPARE_EARLY_EXIT_EN`, 4 without.
- GEU, 0x00000100 vs 0x000000FF → `res_o`=1, latency 3 (early exit), 4 otherwise.
- Backpressure: hold `ready_i`=0 for 5 cycles in DONE and pulse `valid_i` with a new request.
  - `valid_o` and `res_o` stay stable; `ready_o`=0; the new request is not captured.
  - On `ready_i`=1, `ready_o`=1 the next cycle.
- Drive `reset_ni`=0 during SCAN at idx=1 → next cycle IDLE, `valid_o`=0, `ready_o`=1, no result emitted.
- WIDTH=32, CHUNK=32, GE, 0x80000000 vs 0x7FFFFFFF → `res_o`=0 with latency 1; undefined op encoding → `res_o`=0.
